// File: rtl/alu_share_ctrl_if.sv
// Bundles the two requester ports, the result port and the completion counters
// of alu_share_ctrl.
interface alu_share_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) ();

  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_inA;
  logic [WIDTH-1:0] a_inB;
  logic [1:0]       a_op;

  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_inA;
  logic [WIDTH-1:0] b_inB;
  logic [1:0]       b_op;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_ans;
  logic             res_carry;
  logic             res_id;

  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  // Requesters and result consumer.
  modport master (
    output a_valid, a_inA, a_inB, a_op,
    output b_valid, b_inA, b_inB, b_op,
    output res_ready,
    input  a_ready, b_ready,
    input  res_valid, res_ans, res_carry, res_id,
    input  cnt_a, cnt_b
  );

  // The shared-ALU controller.
  modport slave (
    input  a_valid, a_inA, a_inB, a_op,
    input  b_valid, b_inA, b_inB, b_op,
    input  res_ready,
    output a_ready, b_ready,
    output res_valid, res_ans, res_carry, res_id,
    output cnt_a, cnt_b
  );

endinterface

// File: rtl/alu_share_ctrl.sv
// One ALU shared by two requesters under round-robin arbitration, one operation in
// flight at a time; results are held until the consumer takes them.
module alu_share_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  alu_share_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } state_e;

  localparam logic [1:0] OpAnd = 2'b00;
  localparam logic [1:0] OpOr  = 2'b01;
  localparam logic [1:0] OpXor = 2'b10;
  localparam logic [1:0] OpAdd = 2'b11;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;  // 0: A wins a tie, 1: B wins a tie
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [1:0]       op_q, op_d;
  logic             id_q, id_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] ans_q, ans_d;
  logic             carry_q, carry_d;
  logic             res_id_q, res_id_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  logic             grant_a;
  logic             grant_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_ans;
  logic             alu_carry;

  // Grants only exist in IDLE and out of reset, so readies never leak during reset.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (rst_n && (state_q == StIdle)) begin
      if (bus.a_valid && bus.b_valid) begin
        grant_a = ~prio_q;
        grant_b = prio_q;
      end else begin
        grant_a = bus.a_valid;
        grant_b = bus.b_valid;
      end
    end
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  assign sum = {1'b0, opa_q} + {1'b0, opb_q};

  always_comb begin
    alu_ans   = '0;
    alu_carry = 1'b0;
    unique case (op_q)
      OpAnd: alu_ans = opa_q & opb_q;
      OpOr:  alu_ans = opa_q | opb_q;
      OpXor: alu_ans = opa_q ^ opb_q;
      OpAdd: {alu_carry, alu_ans} = sum;
      default: alu_ans = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    id_d     = id_q;
    valid_d  = valid_q;
    ans_d    = ans_q;
    carry_d  = carry_q;
    res_id_d = res_id_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;

    unique case (state_q)
      StIdle: begin
        if (grant_a) begin
          opa_d   = bus.a_inA;
          opb_d   = bus.a_inB;
          op_d    = bus.a_op;
          id_d    = 1'b0;
          state_d = StExec;
        end else if (grant_b) begin
          opa_d   = bus.b_inA;
          opb_d   = bus.b_inB;
          op_d    = bus.b_op;
          id_d    = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        ans_d    = alu_ans;
        carry_d  = alu_carry;
        res_id_d = id_q;
        valid_d  = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        if (bus.res_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
          prio_d  = ~res_id_q;
          if (!res_id_q) begin
            if (cnt_a_q != '1) cnt_a_d = cnt_a_q + CNT_W'(1);
          end else begin
            if (cnt_b_q != '1) cnt_b_d = cnt_b_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      prio_q   <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      id_q     <= 1'b0;
      valid_q  <= 1'b0;
      ans_q    <= '0;
      carry_q  <= 1'b0;
      res_id_q <= 1'b0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      id_q     <= id_d;
      valid_q  <= valid_d;
      ans_q    <= ans_d;
      carry_q  <= carry_d;
      res_id_q <= res_id_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
    end
  end

  assign bus.res_valid = valid_q;
  assign bus.res_ans   = ans_q;
  assign bus.res_carry = carry_q;
  assign bus.res_id    = res_id_q;
  assign bus.cnt_a     = cnt_a_q;
  assign bus.cnt_b     = cnt_b_q;

  a_one_grant: assert property (@(posedge clk) !(bus.a_ready && bus.b_ready));

  a_result_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StDone && !bus.res_ready) |=>
      (valid_q && $stable(ans_q) && $stable(carry_q) && $stable(res_id_q)));

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: hand-computed results, arbitration order,
// stall, reset and counter saturation.
module tb_alu_share_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_share_ctrl_if #(.WIDTH(4), .CNT_W(8)) bus ();

  alu_share_ctrl #(
    .WIDTH(4),
    .CNT_W(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond_of(input int sel);
    if (sel == 0) return bus.a_ready | bus.b_ready;
    return bus.res_valid;
  endfunction

  // Bounded wait: sel 0 = any ready, sel 1 = res_valid.
  task automatic wait_cond(input int sel, input string tag);
    int n = 0;
    while (!cond_of(sel) && n < 20) begin
      tick();
      n++;
    end
    check_val(tag, 32'(cond_of(sel)), 32'd1);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  // Single-requester transaction with the consumer always ready.
  task automatic issue(input logic who, input logic [1:0] op, input logic [3:0] x,
                       input logic [3:0] y, input logic [3:0] ea, input logic ec,
                       input string tag);
    int n = 0;
    bus.res_ready = 1'b1;
    if (!who) begin
      bus.a_valid = 1'b1; bus.a_op = op; bus.a_inA = x; bus.a_inB = y;
    end else begin
      bus.b_valid = 1'b1; bus.b_op = op; bus.b_inA = x; bus.b_inB = y;
    end
    #1;
    while (!(who ? bus.b_ready : bus.a_ready) && n < 10) begin
      tick();
      n++;
    end
    check_val({tag, "_ready"}, 32'(who ? bus.b_ready : bus.a_ready), 32'd1);
    tick();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    check_val({tag, "_exec_vld"}, 32'(bus.res_valid), 32'd0);
    tick();
    check_val({tag, "_vld"}, 32'(bus.res_valid), 32'd1);
    check_val({tag, "_ans"}, 32'(bus.res_ans), 32'(ea));
    check_val({tag, "_carry"}, 32'(bus.res_carry), 32'(ec));
    check_val({tag, "_id"}, 32'(bus.res_id), 32'(who));
    tick();
    check_val({tag, "_idle_vld"}, 32'(bus.res_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.a_valid   = 1'b1;
    bus.b_valid   = 1'b1;
    bus.a_inA     = '0; bus.a_inB = '0; bus.a_op = '0;
    bus.b_inA     = '0; bus.b_inB = '0; bus.b_op = '0;
    bus.res_ready = 1'b0;

    // Reset state, with both requesters pending
    tick();
    tick();
    check_val("rst_a_ready", 32'(bus.a_ready), 32'd0);
    check_val("rst_b_ready", 32'(bus.b_ready), 32'd0);
    check_val("rst_vld", 32'(bus.res_valid), 32'd0);
    check_val("rst_ans", 32'(bus.res_ans), 32'd0);
    check_val("rst_cnt_a", 32'(bus.cnt_a), 32'd0);
    check_val("rst_cnt_b", 32'(bus.cnt_b), 32'd0);
    do_reset();

    // ADD overflow: F + 1 = 0 carry 1
    issue(1'b0, 2'b11, 4'hF, 4'h1, 4'h0, 1'b1, "add_ovf");
    check_val("add_ovf_cnt_a", 32'(bus.cnt_a), 32'd1);

    // All opcodes on C, A
    issue(1'b0, 2'b00, 4'hC, 4'hA, 4'h8, 1'b0, "and");
    issue(1'b0, 2'b01, 4'hC, 4'hA, 4'hE, 1'b0, "or");
    issue(1'b0, 2'b10, 4'hC, 4'hA, 4'h6, 1'b0, "xor");
    issue(1'b0, 2'b11, 4'hC, 4'hA, 4'h6, 1'b1, "add");
    check_val("ops_cnt_a", 32'(bus.cnt_a), 32'd5);
    check_val("ops_cnt_b", 32'(bus.cnt_b), 32'd0);

    // Both valid continuously: A,B,A,B
    do_reset();
    bus.res_ready = 1'b1;
    bus.a_valid = 1'b1; bus.a_op = 2'b00; bus.a_inA = 4'h7; bus.a_inB = 4'hC;
    bus.b_valid = 1'b1; bus.b_op = 2'b10; bus.b_inA = 4'h9; bus.b_inB = 4'h3;
    #1;
    for (int k = 0; k < 4; k++) begin
      wait_cond(0, "rr_ready_wait");
      check_val("rr_grant", 32'({bus.a_ready, bus.b_ready}),
                (k % 2 == 0) ? 32'd2 : 32'd1);
      tick();
      wait_cond(1, "rr_vld_wait");
      check_val("rr_id", 32'(bus.res_id), 32'(k % 2));
      check_val("rr_ans", 32'(bus.res_ans), (k % 2 == 0) ? 32'h4 : 32'hA);
      tick();
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    check_val("rr_cnt_a", 32'(bus.cnt_a), 32'd2);
    check_val("rr_cnt_b", 32'(bus.cnt_b), 32'd2);

    // B stalled by consumer for 10 cycles
    do_reset();
    bus.res_ready = 1'b0;
    bus.b_valid = 1'b1; bus.b_op = 2'b01; bus.b_inA = 4'hA; bus.b_inB = 4'h5;
    #1;
    wait_cond(0, "stall_ready_wait");
    check_val("stall_b_ready", 32'(bus.b_ready), 32'd1);
    tick();
    bus.b_inA = 4'h0;
    tick();
    for (int i = 0; i < 10; i++) begin
      check_val("stall_vld", 32'(bus.res_valid), 32'd1);
      check_val("stall_ans", 32'(bus.res_ans), 32'hF);
      check_val("stall_b_ready_low", 32'(bus.b_ready), 32'd0);
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    check_val("stall_rel_vld", 32'(bus.res_valid), 32'd0);
    check_val("stall_cnt_b", 32'(bus.cnt_b), 32'd1);
    check_val("stall_idle_b_ready", 32'(bus.b_ready), 32'd1);
    bus.b_valid = 1'b0;
    #1;
    check_val("withdraw_b_ready", 32'(bus.b_ready), 32'd0);
    tick();
    check_val("withdraw_vld", 32'(bus.res_valid), 32'd0);
    check_val("withdraw_cnt_b", 32'(bus.cnt_b), 32'd1);

    // Reset while a result waits in DONE
    bus.res_ready = 1'b0;
    bus.a_valid = 1'b1; bus.a_op = 2'b00; bus.a_inA = 4'hC; bus.a_inB = 4'hA;
    #1;
    wait_cond(0, "rstdone_ready_wait");
    tick();
    tick();
    check_val("rstdone_vld_pre", 32'(bus.res_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rstdone_a_ready_in_rst", 32'(bus.a_ready), 32'd0);
    tick();
    check_val("rstdone_vld", 32'(bus.res_valid), 32'd0);
    check_val("rstdone_ans", 32'(bus.res_ans), 32'd0);
    check_val("rstdone_cnt_a", 32'(bus.cnt_a), 32'd0);
    check_val("rstdone_cnt_b", 32'(bus.cnt_b), 32'd0);
    check_val("rstdone_a_ready_rst", 32'(bus.a_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check_val("rstdone_a_ready_idle", 32'(bus.a_ready), 32'd1);

    // Saturation: A back-to-back, one completion every 3 cycles
    bus.res_ready = 1'b1;
    bus.a_op = 2'b11;
    repeat (300) tick();
    check_val("sat_cnt_100", 32'(bus.cnt_a), 32'd100);
    repeat (465) tick();
    check_val("sat_cnt_255", 32'(bus.cnt_a), 32'd255);
    repeat (9) tick();
    check_val("sat_cnt_hold", 32'(bus.cnt_a), 32'd255);
    check_val("sat_cnt_b", 32'(bus.cnt_b), 32'd0);
    bus.a_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
